// File: rtl/fft_mem_pkg.sv
// Shared frame-layout definitions for the BRAM-to-FFT loader and the FFT
// result writer, so both sides agree on where and how frames are stored.
package fft_mem_pkg;

    // Writer / loader control states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Width of one BRAM word and of one FFT lane.
    localparam int BYTE_W    = 8;

    // Default frame layout: points per frame, frames per run, byte address
    // of frame 0 byte 0. Bytes are stored interleaved re0, im0, re1, im1, ...
    localparam int FFTN      = 8;
    localparam int FRAMES    = 3;
    localparam int BASE_ADDR = 100;

    // Number of bytes one frame occupies in memory.
    function automatic int frame_bytes(input int n_points);
        return 2 * n_points;
    endfunction

endpackage

// File: rtl/fft_frame_writer.sv
// Serialises packed FFT output frames (real + imaginary lane vectors) into a
// byte-wide BRAM port, interleaving real/imag bytes, and raises done after a
// fixed number of frames.
module fft_frame_writer
    import fft_mem_pkg::*;
#(
    parameter int FFTN      = fft_mem_pkg::FFTN,
    parameter int FRAMES    = fft_mem_pkg::FRAMES,
    parameter int BASE_ADDR = fft_mem_pkg::BASE_ADDR,
    parameter int ADDR_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_clear,
    input  logic                     i_in_valid,
    output logic                     o_in_ready,
    input  logic [BYTE_W*FFTN-1:0]   i_in_re,
    input  logic [BYTE_W*FFTN-1:0]   i_in_im,
    output logic [ADDR_W-1:0]        o_mem_addr,
    output logic [BYTE_W-1:0]        o_mem_din,
    output logic                     o_mem_wen,
    output logic [7:0]               o_frame_cnt,
    output logic                     o_done
);

    localparam int NBYTES = frame_bytes(FFTN);
    localparam int K_W    = $clog2(NBYTES + 1);
    localparam int LANE_W = $clog2(FFTN);

    localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] STRIDE_A = ADDR_W'(NBYTES);
    localparam logic [K_W-1:0]    K_END    = K_W'(NBYTES);
    localparam logic [7:0]        CNT_END  = 8'(FRAMES);

    state_t                    r_state;
    state_t                    w_state_next;
    logic [K_W-1:0]            r_k, w_k_next;
    logic [BYTE_W*FFTN-1:0]    r_re, w_re_next;
    logic [BYTE_W*FFTN-1:0]    r_im, w_im_next;
    logic [7:0]                r_frame_cnt, w_cnt_next;
    logic [ADDR_W-1:0]         r_mem_addr, w_addr_next;
    logic [BYTE_W-1:0]         r_mem_din, w_din_next;
    logic                      r_mem_wen, w_wen_next;
    logic                      r_done, w_done_next;

    logic [BYTE_W-1:0]         w_re_lane [FFTN];
    logic [BYTE_W-1:0]         w_im_lane [FFTN];
    logic [LANE_W-1:0]         w_lane_idx;
    logic [BYTE_W-1:0]         w_sel_byte;
    logic [ADDR_W-1:0]         w_frame_base;
    logic [7:0]                w_cnt_inc;

    // Split the captured vectors into addressable byte lanes.
    genvar gi;
    generate
        for (gi = 0; gi < FFTN; gi++) begin : g_lane
            assign w_re_lane[gi] = r_re[BYTE_W*gi +: BYTE_W];
            assign w_im_lane[gi] = r_im[BYTE_W*gi +: BYTE_W];
        end
    endgenerate

    // Byte k: lane k>>1, imaginary when k is odd.
    assign w_lane_idx   = r_k[LANE_W:1];
    assign w_sel_byte   = r_k[0] ? w_im_lane[w_lane_idx] : w_re_lane[w_lane_idx];

    // Start address of the frame about to be written (wraps modulo 2^ADDR_W).
    assign w_frame_base = BASE_A + STRIDE_A * ADDR_W'(r_frame_cnt);
    assign w_cnt_inc    = r_frame_cnt + 8'd1;

    assign o_in_ready   = (r_state == IDLE);
    assign o_mem_addr   = r_mem_addr;
    assign o_mem_din    = r_mem_din;
    assign o_mem_wen    = r_mem_wen;
    assign o_frame_cnt  = r_frame_cnt;
    assign o_done       = r_done;

    // State and datapath registers; async reset drops the write strobe at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_k         <= '0;
            r_re        <= '0;
            r_im        <= '0;
            r_frame_cnt <= '0;
            r_mem_addr  <= '0;
            r_mem_din   <= '0;
            r_mem_wen   <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_k         <= w_k_next;
            r_re        <= w_re_next;
            r_im        <= w_im_next;
            r_frame_cnt <= w_cnt_next;
            r_mem_addr  <= w_addr_next;
            r_mem_din   <= w_din_next;
            r_mem_wen   <= w_wen_next;
            r_done      <= w_done_next;
        end
    end

    // Next-state and next-output decode. Byte 0 is emitted straight from the
    // input bus on the handshake edge so that writes follow with no bubble;
    // r_k then holds the index of the next byte to emit.
    always_comb begin
        w_state_next = r_state;
        w_k_next     = r_k;
        w_re_next    = r_re;
        w_im_next    = r_im;
        w_cnt_next   = r_frame_cnt;
        w_addr_next  = r_mem_addr;
        w_din_next   = r_mem_din;
        w_wen_next   = 1'b0;
        w_done_next  = r_done;

        if (i_clear) begin
            w_state_next = IDLE;
            w_k_next     = '0;
            w_cnt_next   = '0;
            w_done_next  = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_in_valid) begin
                        w_re_next    = i_in_re;
                        w_im_next    = i_in_im;
                        w_addr_next  = w_frame_base;
                        w_din_next   = i_in_re[BYTE_W-1:0];
                        w_wen_next   = 1'b1;
                        w_k_next     = K_W'(1);
                        w_state_next = WRITE;
                    end
                end
                WRITE: begin
                    if (r_k == K_END) begin
                        w_k_next   = '0;
                        w_cnt_next = w_cnt_inc;
                        if (w_cnt_inc == CNT_END) begin
                            w_state_next = DONE;
                            w_done_next  = 1'b1;
                        end else begin
                            w_state_next = IDLE;
                        end
                    end else begin
                        w_addr_next = r_mem_addr + ADDR_W'(1);
                        w_din_next  = w_sel_byte;
                        w_wen_next  = 1'b1;
                        w_k_next    = r_k + K_W'(1);
                    end
                end
                DONE: begin
                    w_done_next = 1'b1;
                end
                default: begin
                    w_state_next = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_frame_writer.sv
// Directed bench for fft_frame_writer: two instances share the stimulus, one
// at the default base address 100 and one at 0xFFF8 to exercise wrap-around.
module tb_fft_frame_writer;

    logic        clk;
    logic        rst;
    logic        clear;
    logic        in_valid;
    logic [63:0] in_re;
    logic [63:0] in_im;

    logic        in_ready,  w_in_ready;
    logic [15:0] mem_addr,  w_mem_addr;
    logic [7:0]  mem_din,   w_mem_din;
    logic        mem_wen,   w_mem_wen;
    logic [7:0]  frame_cnt, w_frame_cnt;
    logic        done,      w_done;

    int n_cmp = 0;
    int n_bad = 0;

    fft_frame_writer #(.FFTN(8), .FRAMES(3), .BASE_ADDR(100), .ADDR_W(16)) u_dut (
        .clk(clk), .rst(rst), .i_clear(clear), .i_in_valid(in_valid),
        .o_in_ready(in_ready), .i_in_re(in_re), .i_in_im(in_im),
        .o_mem_addr(mem_addr), .o_mem_din(mem_din), .o_mem_wen(mem_wen),
        .o_frame_cnt(frame_cnt), .o_done(done)
    );

    fft_frame_writer #(.FFTN(8), .FRAMES(3), .BASE_ADDR(16'hFFF8), .ADDR_W(16)) u_dut_wrap (
        .clk(clk), .rst(rst), .i_clear(clear), .i_in_valid(in_valid),
        .o_in_ready(w_in_ready), .i_in_re(in_re), .i_in_im(in_im),
        .o_mem_addr(w_mem_addr), .o_mem_din(w_mem_din), .o_mem_wen(w_mem_wen),
        .o_frame_cnt(w_frame_cnt), .o_done(w_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Lane i of re = re0+i, lane i of im = im0+i.
    task automatic set_frame(input logic [7:0] re0, input logic [7:0] im0);
        for (int i = 0; i < 8; i++) begin
            in_re[8*i +: 8] = re0 + 8'(i);
            in_im[8*i +: 8] = im0 + 8'(i);
        end
    endtask

    // Expects the handshake on the next posedge; checks bytes 0..last_k of
    // frame index f. At the k=0 sample the inputs are replaced by the next
    // frame's data (and in_valid optionally dropped).
    task automatic write_frame(input int f, input logic [7:0] re0, input logic [7:0] im0,
                               input bit drop_valid, input logic [7:0] nre0,
                               input logic [7:0] nim0, input int last_k);
        logic [15:0] base, wbase, ea, wa;
        logic [7:0]  ed;
        base  = 16'(100 + 16 * f);
        wbase = 16'(32'hFFF8 + 32'(16 * f));
        for (int k = 0; k <= last_k; k++) begin
            @(negedge clk);
            if (k == 0) begin
                check_val("ready_low_in_write", 32'(in_ready), 32'd0);
                if (drop_valid) in_valid = 1'b0;
                set_frame(nre0, nim0);
            end
            ea = 16'(base + 16'(k));
            wa = 16'(wbase + 16'(k));
            ed = (k % 2 == 0) ? re0 + 8'(k / 2) : im0 + 8'(k / 2);
            check_val($sformatf("wen f%0d k%0d", f, k), 32'(mem_wen), 32'd1);
            check_val($sformatf("addr f%0d k%0d", f, k), 32'(mem_addr), 32'(ea));
            check_val($sformatf("din f%0d k%0d", f, k), 32'(mem_din), 32'(ed));
            check_val($sformatf("wrap_addr f%0d k%0d", f, k), 32'(w_mem_addr), 32'(wa));
            check_val($sformatf("wrap_din f%0d k%0d", f, k), 32'(w_mem_din), 32'(ed));
        end
        $display("frame %0d: base %0d wrap base %04h bytes 0..%0d checked", f, base, wbase, last_k);
    endtask

    task automatic idle_check(input string tag, input logic [7:0] cnt, input bit dn, input bit rdy);
        check_val({tag, "_wen"},   32'(mem_wen),   32'd0);
        check_val({tag, "_wwen"},  32'(w_mem_wen), 32'd0);
        check_val({tag, "_cnt"},   32'(frame_cnt), 32'(cnt));
        check_val({tag, "_done"},  32'(done),      32'(dn));
        check_val({tag, "_ready"}, 32'(in_ready),  32'(rdy));
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        clear    = 1'b0;
        in_valid = 1'b0;
        in_re    = '0;
        in_im    = '0;

        // Reset values
        repeat (3) @(negedge clk);
        idle_check("reset", 8'd0, 1'b0, 1'b1);
        check_val("reset_addr", 32'(mem_addr), 32'd0);
        check_val("reset_din",  32'(mem_din),  32'd0);
        rst = 1'b0;
        @(negedge clk);
        idle_check("post_reset", 8'd0, 1'b0, 1'b1);

        // Single frame: re 0x10.., im 0x20.. (wrap instance covers 0xFFF8..0x0007)
        set_frame(8'h10, 8'h20);
        in_valid = 1'b1;
        write_frame(0, 8'h10, 8'h20, 1'b1, 8'hAA, 8'hBB, 15);
        @(negedge clk);
        idle_check("single_end", 8'd1, 1'b0, 1'b1);
        $display("single frame complete");

        pulse_clear();
        idle_check("clear1", 8'd0, 1'b0, 1'b1);

        // Three back-to-back frames with in_valid held
        set_frame(8'h30, 8'h80);
        in_valid = 1'b1;
        for (int f = 0; f < 3; f++) begin
            write_frame(f, 8'(8'h30 + 16 * f), 8'(8'h80 + 16 * f), 1'b0,
                        8'(8'h30 + 16 * (f + 1)), 8'(8'h80 + 16 * (f + 1)), 15);
            @(negedge clk);
            idle_check($sformatf("b2b_gap%0d", f), 8'(f + 1), (f == 2), (f != 2));
        end

        // DONE ignores in_valid with fresh data
        set_frame(8'hEE, 8'hEF);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            idle_check($sformatf("done_hold%0d", i), 8'd3, 1'b1, 1'b0);
        end
        in_valid = 1'b0;

        pulse_clear();
        idle_check("clear_done", 8'd0, 1'b0, 1'b1);
        $display("done/clear sequence complete");

        // After clear the next frame lands at 100 again
        set_frame(8'h01, 8'h81);
        in_valid = 1'b1;
        write_frame(0, 8'h01, 8'h81, 1'b1, 8'h00, 8'h00, 15);
        @(negedge clk);
        idle_check("after_clear", 8'd1, 1'b0, 1'b1);

        // Clear at k=5 of frame 1 aborts the frame
        set_frame(8'hC0, 8'hD0);
        in_valid = 1'b1;
        write_frame(1, 8'hC0, 8'hD0, 1'b1, 8'h00, 8'h00, 5);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        idle_check("abort", 8'd0, 1'b0, 1'b1);
        @(negedge clk);
        idle_check("abort_hold", 8'd0, 1'b0, 1'b1);
        set_frame(8'hE0, 8'hF0);
        in_valid = 1'b1;
        write_frame(0, 8'hE0, 8'hF0, 1'b1, 8'h00, 8'h00, 15);
        @(negedge clk);
        idle_check("restart", 8'd1, 1'b0, 1'b1);

        // Asynchronous reset at k=9 of frame 1
        set_frame(8'h55, 8'h66);
        in_valid = 1'b1;
        write_frame(1, 8'h55, 8'h66, 1'b1, 8'h00, 8'h00, 9);
        #2;
        rst = 1'b1;
        #1;
        idle_check("async_rst", 8'd0, 1'b0, 1'b1);
        check_val("async_rst_addr", 32'(mem_addr), 32'd0);
        check_val("async_rst_din",  32'(mem_din),  32'd0);
        $display("async reset mid-frame checked");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        set_frame(8'h07, 8'h09);
        in_valid = 1'b1;
        write_frame(0, 8'h07, 8'h09, 1'b1, 8'h00, 8'h00, 15);
        @(negedge clk);
        idle_check("post_rst_frame", 8'd1, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
